// File: rtl/cache_fill_ctrl_if.sv
// cache_fill_ctrl_if: miss, memory-read and cache-fill signals of cache_fill_ctrl
interface cache_fill_ctrl_if #(
  parameter int ARCH_WIDTH = 16,
  parameter int BLOCK_WORDS = 8
);
  localparam int OW = $clog2(BLOCK_WORDS);
  logic ic_miss;
  logic [ARCH_WIDTH-1:0] ic_miss_addr;
  logic dc_miss;
  logic [ARCH_WIDTH-1:0] dc_miss_addr;
  logic mem_en;
  logic [ARCH_WIDTH-1:0] mem_addr;
  logic mem_rvalid;
  logic [ARCH_WIDTH-1:0] mem_rdata;
  logic fill_we;
  logic [OW-1:0] fill_word;
  logic [ARCH_WIDTH-1:0] fill_data;
  logic fill_sel;
  logic fill_done;
  logic ic_req;
  logic ic_hit;
  modport master (
    input ic_miss, ic_miss_addr, dc_miss, dc_miss_addr, mem_rvalid, mem_rdata,
    output mem_en, mem_addr, fill_we, fill_word, fill_data, fill_sel, fill_done, ic_req, ic_hit
  );
  modport slave (
    output ic_miss, ic_miss_addr, dc_miss, dc_miss_addr, mem_rvalid, mem_rdata,
    input mem_en, mem_addr, fill_we, fill_word, fill_data, fill_sel, fill_done, ic_req, ic_hit
  );
endinterface

// File: rtl/cache_fill_ctrl.sv
// cache_fill_ctrl: I/D block-fill FSM with D-cache priority; CRIT_WORD_FIRST_EN starts the fill at the missed word
module cache_fill_ctrl #(
  parameter int ARCH_WIDTH = 16,
  parameter int BLOCK_WORDS = 8
) (
  input logic clk,
  input logic rst,
  cache_fill_ctrl_if.master bus
);
  localparam int OW = $clog2(BLOCK_WORDS);
  localparam logic [OW:0] NW = (OW + 1)'(BLOCK_WORDS);
  localparam logic [OW:0] NW_M1 = (OW + 1)'(BLOCK_WORDS - 1);
  localparam logic [ARCH_WIDTH-1:0] LOW = ARCH_WIDTH'((1 << (OW + 1)) - 1);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
  state_t state_q, state_d;
  logic [ARCH_WIDTH-1:0] addr_q, addr_d, mem_addr_q, mem_addr_d, miss_addr;
  logic [OW-1:0] iss_idx_q, iss_idx_d, rcv_idx_q, rcv_idx_d, start;
  logic [OW:0] iss_cnt_q, iss_cnt_d, rcv_cnt_q, rcv_cnt_d;
  logic mem_en_q, mem_en_d, fill_sel_q, fill_sel_d, fill_done_q, fill_done_d;
  logic ic_req_q, ic_req_d, ic_hit_q, ic_hit_d;
  logic accept, issuing, rx, last_rx;
  function automatic logic [ARCH_WIDTH-1:0] word_addr(input logic [ARCH_WIDTH-1:0] a, input logic [OW-1:0] i);
    return (a & ~LOW) | ARCH_WIDTH'({i, 1'b0});
  endfunction
  assign miss_addr = bus.dc_miss ? bus.dc_miss_addr : bus.ic_miss_addr;
`ifdef CRIT_WORD_FIRST_EN
  assign start = miss_addr[OW:1];
`else
  assign start = '0;
`endif
  assign accept = state_q == IDLE && (bus.dc_miss || bus.ic_miss);
  assign issuing = state_q == ISSUE && iss_cnt_q != NW;
  assign rx = rst && bus.mem_rvalid && (state_q == ISSUE || state_q == DRAIN);
  assign last_rx = rx && rcv_cnt_q == NW_M1;
  always_comb begin
    state_d = last_rx ? DONE : state_q == DONE ? IDLE : accept ? ISSUE :
              (state_q == ISSUE && !issuing) ? DRAIN : state_q;
    addr_d = accept ? miss_addr : addr_q;
    fill_sel_d = accept ? bus.dc_miss : fill_sel_q;
    mem_en_d = accept || issuing;
    mem_addr_d = accept ? word_addr(miss_addr, start) : issuing ? word_addr(addr_q, iss_idx_q) : '0;
    iss_idx_d = accept ? start + OW'(1) : issuing ? iss_idx_q + OW'(1) : iss_idx_q;
    iss_cnt_d = accept ? (OW + 1)'(1) : issuing ? iss_cnt_q + (OW + 1)'(1) : iss_cnt_q;
    rcv_idx_d = accept ? start : rx ? rcv_idx_q + OW'(1) : rcv_idx_q;
    rcv_cnt_d = accept ? '0 : rx ? rcv_cnt_q + (OW + 1)'(1) : rcv_cnt_q;
    fill_done_d = last_rx;
    ic_req_d = state_q == IDLE && !(bus.ic_miss && bus.dc_miss);
    ic_hit_d = state_q == IDLE && !bus.ic_miss;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      addr_q <= '0;
      fill_sel_q <= 1'b0;
      mem_en_q <= 1'b0;
      mem_addr_q <= '0;
      iss_idx_q <= '0;
      iss_cnt_q <= '0;
      rcv_idx_q <= '0;
      rcv_cnt_q <= '0;
      fill_done_q <= 1'b0;
      ic_req_q <= 1'b0;
      ic_hit_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      fill_sel_q <= fill_sel_d;
      mem_en_q <= mem_en_d;
      mem_addr_q <= mem_addr_d;
      iss_idx_q <= iss_idx_d;
      iss_cnt_q <= iss_cnt_d;
      rcv_idx_q <= rcv_idx_d;
      rcv_cnt_q <= rcv_cnt_d;
      fill_done_q <= fill_done_d;
      ic_req_q <= ic_req_d;
      ic_hit_q <= ic_hit_d;
    end
  end
  assign bus.mem_en = mem_en_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.fill_we = rx;
  assign bus.fill_word = rcv_idx_q;
  assign bus.fill_data = rst ? bus.mem_rdata : '0;
  assign bus.fill_sel = fill_sel_q;
  assign bus.fill_done = fill_done_q;
  assign bus.ic_req = ic_req_q;
  assign bus.ic_hit = ic_hit_q;
endmodule

// File: doc/cache_fill_ctrl.md
CACHE_FILL_CTRL -- requirements
Module: cache_fill_ctrl

Interface
REQ-001 Parameter ARCH_WIDTH, default 16, address/data width.
REQ-002 Parameter BLOCK_WORDS, default 8, words per cache block; must be a power of 2.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset: synchronous, active-low.
REQ-005 ic_miss  input  1  I-cache miss; held high until the fill completes.
REQ-006 ic_miss_addr  input  ARCH_WIDTH  I-cache missing byte address.
REQ-007 dc_miss  input  1  D-cache miss; held high until the fill completes.
REQ-008 dc_miss_addr  input  ARCH_WIDTH  D-cache missing byte address.
REQ-009 mem_en  output  1  main-memory read request, one word per cycle.
REQ-010 mem_addr  output  ARCH_WIDTH  main-memory word byte-address.
REQ-011 mem_rvalid  input  1  returned read data valid, in issue order.
REQ-012 mem_rdata  input  ARCH_WIDTH  returned read data.
REQ-013 fill_we  output  1  write one word into the selected cache data array.
REQ-014 fill_word  output  log2(BLOCK_WORDS)  word index within the block being written.
REQ-015 fill_data  output  ARCH_WIDTH  word being written; equals mem_rdata.
REQ-016 fill_sel  output  1  target cache: 0 = I-cache, 1 = D-cache.
REQ-017 fill_done  output  1  one-cycle pulse that writes the tag and valid bit of the filled block.
REQ-018 ic_req / ic_hit  output  1 each  per-cycle I-cache access statistic strobes for the trace monitor.

Function
REQ-019 FSM states are IDLE, ISSUE, DRAIN and DONE; the state is IDLE after reset.
REQ-020 IDLE: if dc_miss, latch dc_miss_addr and set fill_sel=1; otherwise, if ic_miss, latch ic_miss_addr and set fill_sel=0; then go to ISSUE.
REQ-021 When both misses are asserted in the same cycle, the D-cache is served first and the I-cache miss is served on the cycle after DONE.
REQ-022 Block base = latched address with its low log2(BLOCK_WORDS)+1 bits cleared.
REQ-023 Word i has address base + 2*i.
REQ-024 ISSUE: mem_en=1 for exactly BLOCK_WORDS consecutive cycles, one word per cycle, then go to DRAIN.
REQ-025 The issue index wraps modulo BLOCK_WORDS.
REQ-026 Each mem_rvalid produces fill_we=1 in the same cycle, with fill_word taken from a receive index that advances in issue order.
REQ-027 mem_rvalid may arrive during ISSUE or DRAIN.
REQ-028 When the BLOCK_WORDS-th word is received, go to DONE; fill_done=1 for exactly that one DONE cycle, then return to IDLE.
REQ-029 The minimum miss-to-fill_done latency is 1 + BLOCK_WORDS + memory latency cycles.
REQ-030 mem_rvalid in IDLE or DONE is ignored: no fill_we, no counter change.
REQ-031 Deassertion of the served miss request mid-fill is ignored; the fill always completes.
REQ-032 Requests are not sampled outside IDLE.
REQ-033 ic_req=1 in every cycle where the controller is IDLE and ic_miss=0 and the I-cache is active (ic_miss_addr valid); ic_hit mirrors it.
REQ-034 ic_req=1 and ic_hit=0 in the IDLE cycle that accepts an I-cache miss.
REQ-035 All outputs are registered except fill_data and fill_we, which are combinational from mem_rvalid, mem_rdata and the state.

Reset
REQ-036 On rst=0 at a clock edge the state becomes IDLE, and the issue and receive counters, latched address and fill_sel clear to 0.
REQ-037 During reset, all outputs are 0.
REQ-038 Reset mid-fill aborts the fill with no fill_done.
REQ-039 Words still returning from memory after reset are discarded per REQ-030.

Configuration
REQ-040 Macro CRIT_WORD_FIRST_EN defined: issue and receive indices start at the missed word offset (address bits [log2(BLOCK_WORDS):1]) and wrap modulo BLOCK_WORDS.
REQ-041 Macro CRIT_WORD_FIRST_EN undefined: both indices start at 0.
REQ-042 All other behaviour is identical with or without CRIT_WORD_FIRST_EN.

Verification
REQ-043 Single D-cache miss at 0x1236, memory latency 4, macro off -> mem_addr 0x1230..0x123E on consecutive cycles; 8 fill_we with fill_word 0..7; fill_done 13 cycles after acceptance.
REQ-044 Same miss with CRIT_WORD_FIRST_EN -> first mem_addr 0x1236, sequence wraps to 0x1234; first fill_word=3.
REQ-045 ic_miss and dc_miss both raised in one cycle -> D fill (fill_sel=1) completes first, then the I fill starts the cycle after fill_done.
REQ-046 rst=0 asserted on the third fill_we of a fill -> no fill_done; all outputs 0; late mem_rvalid produces no fill_we.
REQ-047 Stray mem_rvalid while IDLE with no miss -> no fill_we and counters unchanged; the next miss still fills words 0..7 correctly.
REQ-048 dc_miss dropped after 2 issued words -> all 8 words still issued and filled, with fill_done pulsing once.
